uart_rx_core: RTL

- Parametrised next-generation UART receive path for the UART/ALU top level.
- Built-in runtime-programmable baud tick generator, 2-FF rx synchroniser, 16x oversampling with 3-sample majority vote, runtime parity mode, false-start rejection, and break handling.
- Receive FIFO with error flags: sticky framing, parity and overrun.
- Replaces the fixed-divisor baud generator + uart_rx + rx FIFO chain.

---
 rtl/uart_rx_core.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive path: programmable oversample tick, 2-FF synchroniser, majority-voted
// frame FSM with parity/break handling, and a first-word fall-through receive FIFO.
module uart_rx_core #(
    parameter int DBIT                  = 8,
    parameter int SB_TICK               = 16,
    parameter int BAUDRATE_DIVISOR_BITS = 8,
    parameter int FIFO_W                = 2
) (
    input  logic                             i_clk,
    input  logic                             reset,
    input  logic [BAUDRATE_DIVISOR_BITS-1:0] i_baud_div,
    input  logic [1:0]                       i_parity_mode,
    input  logic                             rx,
    input  logic                             rd_uart,
    input  logic                             i_clr_err,
    output logic [DBIT-1:0]                  r_data,
    output logic                             rx_empty,
    output logic                             rx_full,
    output logic                             o_frame_err,
    output logic                             o_parity_err,
    output logic                             o_overrun
);

    localparam int DW    = BAUDRATE_DIVISOR_BITS;
    localparam int SW    = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int DEPTH = 2 ** FIFO_W;

    localparam logic [SW-1:0]     S_SAMP0     = SW'(7);
    localparam logic [SW-1:0]     S_SAMP1     = SW'(8);
    localparam logic [SW-1:0]     S_SAMP2     = SW'(9);
    localparam logic [SW-1:0]     S_LAST      = SW'(15);
    localparam logic [SW-1:0]     S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]        N_LAST      = 3'(DBIT - 1);
    localparam logic [FIFO_W:0]   CNT_FULL    = (FIFO_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic even_parity(input logic [DBIT-1:0] d);
        return ^d;
    endfunction

    logic [DW-1:0]     div_r;
    logic [DW-1:0]     cnt_r;
    logic              tick_s;
    logic              rx_meta_r;
    logic              rxs_r;
    state_t            state_r;
    logic [SW-1:0]     s_r;
    logic [2:0]        n_r;
    logic [DBIT-1:0]   data_r;
    logic [1:0]        smp_r;
    logic              maj_r;
    logic              stop_r;
    logic              par_bad_r;
    logic              armed_r;
    logic              maj_now_s;
    logic              par_on_s;
    logic              end_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_s;
    logic              frame_set_s;
    logic              parity_set_s;
    logic              overrun_set_s;
    logic [DBIT-1:0]   mem_r [DEPTH];
    logic [FIFO_W-1:0] wptr_r;
    logic [FIFO_W-1:0] rptr_r;
    logic [FIFO_W:0]   count_r;
    logic [FIFO_W:0]   count_nxt_s;

    assign tick_s        = (div_r != '0) && (cnt_r == (div_r - DW'(1)));
    assign maj_now_s     = majority3(smp_r[0], smp_r[1], rxs_r);
    assign par_on_s      = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
    assign end_s         = (state_r == STOP) && tick_s && (s_r == S_STOP_LAST);
    assign push_s        = end_s && stop_r;
    assign frame_set_s   = end_s && !stop_r;
    assign parity_set_s  = push_s && par_bad_r;
    assign pop_s         = rd_uart && !rx_empty;
    assign wr_s          = push_s && (!rx_full || pop_s);
    assign overrun_set_s = push_s && rx_full && !pop_s;
    assign r_data        = mem_r[rptr_r];

    // Oversample tick counter; the divisor is only reloaded at a wrap (or while idle at 0).
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            div_r <= '0;
            cnt_r <= '0;
        end else if ((div_r == '0) || tick_s) begin
            div_r <= i_baud_div;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Frame FSM: samples at s=7/8/9, decisions at the end of each bit period.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            s_r       <= '0;
            n_r       <= 3'd0;
            data_r    <= '0;
            smp_r     <= 2'b11;
            maj_r     <= 1'b1;
            stop_r    <= 1'b1;
            par_bad_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            if (tick_s && (state_r != IDLE)) begin
                if (s_r == S_SAMP0) smp_r[0] <= rxs_r;
                if (s_r == S_SAMP1) smp_r[1] <= rxs_r;
                if (s_r == S_SAMP2) maj_r    <= maj_now_s;
            end
            case (state_r)
                IDLE: begin
                    if (rxs_r) begin
                        armed_r <= 1'b1;
                    end else if (armed_r) begin
                        state_r   <= START;
                        s_r       <= '0;
                        par_bad_r <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if ((s_r == S_SAMP2) && maj_now_s) begin
                            state_r <= IDLE;
                            s_r     <= '0;
                        end else if (s_r == S_LAST) begin
                            state_r <= DATA;
                            s_r     <= '0;
                            n_r     <= 3'd0;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (s_r == S_LAST) begin
                            data_r[n_r] <= maj_r;
                            s_r         <= '0;
                            if (n_r == N_LAST) begin
                                state_r <= par_on_s ? PARITY : STOP;
                            end else begin
                                n_r <= n_r + 3'd1;
                            end
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        if (s_r == S_LAST) begin
                            par_bad_r <= maj_r != (even_parity(data_r) ^ i_parity_mode[1]);
                            state_r   <= STOP;
                            s_r       <= '0;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (s_r == S_SAMP2) stop_r <= maj_now_s;
                        if (s_r == S_STOP_LAST) begin
                            state_r <= IDLE;
                            s_r     <= '0;
                            // A low stop bit disarms IDLE so a held break reports only once.
                            if (!stop_r) armed_r <= 1'b0;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    s_r     <= '0;
                end
            endcase
        end
    end

    // Next FIFO occupancy from the accepted push and pop.
    always_comb begin
        count_nxt_s = count_r;
        if (wr_s && !pop_s) begin
            count_nxt_s = count_r + (FIFO_W + 1)'(1);
        end else if (!wr_s && pop_s) begin
            count_nxt_s = count_r - (FIFO_W + 1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers and registered empty/full flags.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            count_r  <= '0;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
        end else begin
            if (wr_s)  wptr_r <= wptr_r + FIFO_W'(1);
            if (pop_s) rptr_r <= rptr_r + FIFO_W'(1);
            count_r  <= count_nxt_s;
            rx_empty <= (count_nxt_s == '0);
            rx_full  <= (count_nxt_s == CNT_FULL);
        end
    end

    // FIFO storage, cleared on reset so the head reads zero.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (wr_s) begin
            mem_r[wptr_r] <= data_r;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err  <= frame_set_s   | (o_frame_err  & ~i_clr_err);
            o_parity_err <= parity_set_s  | (o_parity_err & ~i_clr_err);
            o_overrun    <= overrun_set_s | (o_overrun    & ~i_clr_err);
        end
    end

endmodule
